// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN
   } pll_state_t;

   // Width for a counter that must reach (largest cycle parameter - 1); never below one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: multi-flop synchronizer bringing the asynchronous lock indication into refclk.
module pll_lock_sync #(
   parameter int STAGES = 2
) (
   input  logic refclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: resets the PLL, waits for a stable lock, then releases the core reset;
// retries on lock timeout and restarts the sequence on lock loss while running.
module pll_lock_seq
   import pll_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1000
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   output logic       pll_rst,
   output logic       core_rst_n,
   output logic       lock_lost,
   output logic [7:0] relock_count,
   output logic       timeout_seen
);

   localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

   pll_state_t    state, state_nxt;
   logic [CW-1:0] cnt;
   logic          locked_s, lost_evt, tmo_evt;

   pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .refclk (refclk),
      .rst_n  (rst_n),
      .d      (locked),
      .q      (locked_s)
   );

   always_comb begin
      state_nxt = state;
      lost_evt  = 1'b0;
      tmo_evt   = 1'b0;
      case (state)
         RESET_PLL: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         WAIT_LOCK: begin
            if (locked_s) state_nxt = STABILIZE;
            else if (cnt == TMO_LAST) begin
               state_nxt = RESET_PLL;
               tmo_evt   = 1'b1;
            end
         end
         // a lock drop beats a coinciding terminal count
         STABILIZE: state_nxt = !locked_s ? WAIT_LOCK : (cnt == STB_LAST) ? RUN : STABILIZE;
         RUN: begin
            if (!locked_s) begin
               state_nxt = RESET_PLL;
               lost_evt  = 1'b1;
            end
         end
         default: state_nxt = RESET_PLL;
      endcase
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RESET_PLL;
         cnt          <= '0;
         lock_lost    <= 1'b0;
         relock_count <= 8'd0;
         timeout_seen <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= (state_nxt != state) ? '0 : (&cnt) ? cnt : cnt + CW'(1);
         lock_lost    <= lost_evt;
         relock_count <= (lost_evt && relock_count != 8'hff) ? relock_count + 8'd1 : relock_count;
         timeout_seen <= timeout_seen | tmo_evt;
      end
   end

   assign pll_rst    = (state == RESET_PLL);
   assign core_rst_n = (state == RUN);

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, 2, synchronizer depth for locked (legal range >=2).
REQ-002 SHALL have parameter PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, 50000, max refclk cycles to wait for lock before retrying (>=1).
REQ-004 SHALL have parameter STABLE_CYCLES, 1000, consecutive locked cycles required before releasing the core (>=1).
REQ-005 SHALL have port refclk  input  1  free-running reference clock; the block's only clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port pll_rst  output  1  active-high reset driven to the PLL.
REQ-009 SHALL have port core_rst_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-010 SHALL have port lock_lost  output  1  one-cycle pulse on loss of lock while running.
REQ-011 SHALL have port relock_count  output  8  saturating count of lock losses in RUN.
REQ-012 SHALL have port timeout_seen  output  1  sticky flag, set by any lock timeout.

Function
REQ-013 SHALL synchronize locked through SYNC_STAGES flops; the last stage is locked_s, and only locked_s SHALL feed the FSM.
REQ-014 SHALL implement the states RESET_PLL, WAIT_LOCK, STABILIZE and RUN, with one shared cycle counter cleared on every state entry.
REQ-015 RESET_PLL SHALL last exactly PLL_RST_CYCLES cycles and then go to WAIT_LOCK.
REQ-016 WAIT_LOCK SHALL go to STABILIZE on the first cycle with locked_s=1.
REQ-017 WAIT_LOCK SHALL go to RESET_PLL and set timeout_seen after LOCK_TIMEOUT cycles with locked_s=0.
REQ-018 STABILIZE SHALL go to RUN when locked_s=1 on its STABLE_CYCLES-th cycle.
REQ-019 STABILIZE SHALL return to WAIT_LOCK on any cycle with locked_s=0, and a lock drop SHALL win over a coinciding terminal count.
REQ-020 RUN SHALL go to RESET_PLL on locked_s=0, pulse lock_lost for one cycle, and increment relock_count, saturating at 255.
REQ-021 pll_rst SHALL equal (state==RESET_PLL) and core_rst_n SHALL equal (state==RUN), both decoded from the state register only, with no combinational path from locked.
REQ-022 Latency SHALL be as follows: with locked held high, core_rst_n rises SYNC_STAGES+STABLE_CYCLES+1 edges after the first edge sampling locked=1.
REQ-023 A glitch on locked shorter than one cycle SHALL NOT be required to be observed, but any sampled low SHALL obey REQ-019 and REQ-020.
REQ-024 The counter SHALL be $clog2 of the largest cycle parameter in width, SHALL never wrap, and SHALL hold at its terminal value until the state changes.

Reset
REQ-025 rst_n low SHALL asynchronously force state=RESET_PLL, the counter to 0, all synchronizer flops to 0, pll_rst=1, core_rst_n=0, lock_lost=0, relock_count=0 and timeout_seen=0.
REQ-026 rst_n assertion mid-operation SHALL override all transitions, and core_rst_n SHALL drop in the same instant.
REQ-027 After rst_n release, pll_rst SHALL stay high for exactly PLL_RST_CYCLES rising edges.

Structure
REQ-028 SHALL define the state enum and the counter-width helper function in shared package pll_seq_pkg.
REQ-029 SHALL instantiate sub-module pll_lock_sync (parameterized SYNC_STAGES, async active-low reset) for locked.
REQ-030 The implementation SHALL fit within 120-400 lines of RTL.

Verification (SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8)
REQ-031 Release rst_n with locked=0 -> pll_rst high for 4 edges, then low; no core release.
REQ-032 Raise locked 2 cycles after pll_rst falls and hold -> core_rst_n rises exactly 11 edges after the first edge sampling locked=1; relock_count=0.
REQ-033 Keep locked=0 -> after 32 WAIT_LOCK cycles pll_rst reasserts for 4 cycles and timeout_seen=1, held through later successful lock.
REQ-034 In STABILIZE drop locked for 1 cycle at count 7 -> WAIT_LOCK, no RUN; re-lock restarts the full 8-cycle stabilize.
REQ-035 In RUN drop locked -> lock_lost pulses once, relock_count 0->1, pll_rst=1 and core_rst_n=0 at SYNC_STAGES+1 edges; 300 forced losses -> relock_count=255.
REQ-036 Assert rst_n asynchronously mid-RUN -> core_rst_n=0 and pll_rst=1 immediately, relock_count=0 and timeout_seen=0.
